// File: rtl/dmem_unit.sv
// Byte-addressable single-port data memory with 1-cycle aligned/extended loads and lane-masked stores.
// Optional macro DMEM_MISALIGN_TRAP_EN suppresses illegal accesses and records them in a sticky fault register.
module dmem_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o,
    output logic        fault_valid_o,
    output logic [31:0] fault_addr_o,
    input  logic        fault_clr_i
);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [1:0]       eff_size;
    logic [1:0]       eff_off;
    logic             do_wr;
    logic             do_rd;
    logic [3:0]       be;
    logic [31:0]      wdata;

    logic [31:0] raw_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;

    assign idx = addr_i[IDX_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic        illegal;
    logic        fault_valid_q;
    logic [31:0] fault_addr_q;

    always_comb begin
        illegal = (size_i == 2'b11) ||
                  (size_i == 2'b01 && addr_i[0]) ||
                  (size_i == 2'b10 && addr_i[1:0] != 2'b00);
        eff_size = size_i;
        eff_off  = addr_i[1:0];
        do_wr    = wr_en_i && !illegal;
        do_rd    = rd_en_i && !wr_en_i && !illegal;
    end

    // A fault arriving with a clear still wins, so the clear only acts when no new fault is captured.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if ((rd_en_i || wr_en_i) && illegal && (!fault_valid_q || fault_clr_i)) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= addr_i;
        end else if (fault_clr_i) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end
    end

    assign fault_valid_o = fault_valid_q;
    assign fault_addr_o  = fault_addr_q;
`else
    logic unused_in;

    // Misaligned accesses are forced down to their natural boundary; size 11 acts as a word.
    always_comb begin
        eff_size = (size_i == 2'b11) ? 2'b10 : size_i;
        eff_off  = addr_i[1:0];
        case (eff_size)
            2'b01:   eff_off = {addr_i[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = addr_i[1:0];
        endcase
        do_wr = wr_en_i;
        do_rd = rd_en_i && !wr_en_i;
    end

    assign unused_in     = ^{fault_clr_i, addr_i};
    assign fault_valid_o = 1'b0;
    assign fault_addr_o  = '0;
`endif

    always_comb begin
        be    = 4'b0000;
        wdata = data_i;
        case (eff_size)
            2'b00: begin
                be    = 4'b0001 << eff_off;
                wdata = {4{data_i[7:0]}};
            end
            2'b01: begin
                be    = eff_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_i[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // A store on the same edge as reset assertion must not land.
    always_ff @(posedge clk) begin
        if (rst_ni && do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q  <= '0;
            off_q  <= '0;
            size_q <= '0;
            sign_q <= 1'b0;
        end else if (do_rd) begin
            raw_q  <= mem[idx];
            off_q  <= eff_off;
            size_q <= eff_size;
            sign_q <= sign_i;
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_q[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? raw_q[31:16] : raw_q[15:0];
        case (size_q)
            2'b00:   data_o = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'b01:   data_o = {{16{sign_q & half_sel[15]}}, half_sel};
            default: data_o = raw_q;
        endcase
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed cases plus random traffic against a byte-array model.
module tb_dmem_unit;

    localparam int BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rd_en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [1:0]  size_i = '0;
    logic        sign_i = 1'b0;
    logic        fault_clr_i = 1'b0;
    logic [31:0] data_o;
    logic        fault_valid_o;
    logic [31:0] fault_addr_o;

    dmem_unit #(.DEPTH_WORDS(1024)) dut (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .rd_en_i       (rd_en_i),
        .wr_en_i       (wr_en_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .size_i        (size_i),
        .sign_i        (sign_i),
        .data_o        (data_o),
        .fault_valid_o (fault_valid_o),
        .fault_addr_o  (fault_addr_o),
        .fault_clr_i   (fault_clr_i)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem_m [BYTES];
    logic [31:0] exp_data = '0;
    logic        exp_fv = 1'b0;
    logic [31:0] exp_fa = '0;
    int          checks = 0;
    int          errors = 0;

    // Drives one request across a rising edge and advances the reference model.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size, input logic sgn,
                          input logic clr);
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] v;
        bit          illegal;
        int          n;
        int          base;
        rd_en_i = rd; wr_en_i = wr; addr_i = addr; data_i = data;
        size_i = size; sign_i = sgn; fault_clr_i = clr;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0; wr_en_i = 1'b0; fault_clr_i = 1'b0;
        sz = size;
        a  = addr;
        illegal = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((rd || wr) && illegal) begin
            if (!exp_fv || clr) begin
                exp_fv = 1'b1;
                exp_fa = addr;
            end
            return;
        end
        if (clr) begin
            exp_fv = 1'b0;
            exp_fa = '0;
        end
`else
        if (illegal && sz == 2'd3) sz = 2'd2;
        if (sz == 2'd1) a = a & ~32'd1;
        else if (sz == 2'd2) a = a & ~32'd3;
`endif
        n = 1 << sz;
        base = int'(a % BYTES);
        if (wr) begin
            for (int i = 0; i < n; i++) mem_m[base+i] = data[8*i +: 8];
        end else if (rd) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[base+i]) << (8*i));
            if (n < 4 && sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            exp_data = v;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h expected %h", data_o, 32'h0);
        end
        checks++;
        if (fault_valid_o !== 1'b0 || fault_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_fault: got %b/%h expected 0/0", fault_valid_o, fault_addr_o);
        end
        #20 rst_ni = 1'b1;
        access(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL idle_after_reset: got %h expected %h", data_o, 32'h0);
        end
    endtask

    task automatic fill_memory;
        for (int w = 0; w < 1024; w++) access(1'b0, 1'b1, w * 4, $urandom, 2'd2, 1'b0, 1'b0);
    endtask

    task automatic test_word_store_byte_load;
        access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 1'b0);
        checks++;
        if (data_o !== 32'hFFFFFFDE) begin
            errors++; $display("FAIL byte_signed: got %h expected %h", data_o, 32'hFFFFFFDE);
        end
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h000000EF) begin
            errors++; $display("FAIL byte_unsigned: got %h expected %h", data_o, 32'h000000EF);
        end
    endtask

    task automatic test_half_store;
        logic [15:0] low;
        low = {mem_m[32'h201], mem_m[32'h200]};
        access(1'b0, 1'b1, 32'h202, 32'h5A5A8001, 2'd1, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h202, 32'h0, 2'd1, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h00008001) begin
            errors++; $display("FAIL half_unsigned: got %h expected %h", data_o, 32'h00008001);
        end
        access(1'b1, 1'b0, 32'h202, 32'h0, 2'd1, 1'b1, 1'b0);
        checks++;
        if (data_o !== 32'hFFFF8001) begin
            errors++; $display("FAIL half_signed: got %h expected %h", data_o, 32'hFFFF8001);
        end
        access(1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== {16'h8001, low}) begin
            errors++; $display("FAIL half_word_view: got %h expected %h", data_o, {16'h8001, low});
        end
    endtask

    task automatic test_back_to_back;
        access(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'hAAAA5555) begin
            errors++; $display("FAIL prior_load: got %h expected %h", data_o, 32'hAAAA5555);
        end
        access(1'b1, 1'b1, 32'h10, 32'h12345678, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'hAAAA5555) begin
            errors++; $display("FAIL rd_wr_hold: got %h expected %h", data_o, 32'hAAAA5555);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h12345678) begin
            errors++; $display("FAIL rd_wr_store: got %h expected %h", data_o, 32'h12345678);
        end
    endtask

    task automatic test_wrap;
        access(1'b0, 1'b1, 32'h1004, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h0004, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL wrap: got %h expected %h", data_o, 32'hCAFEF00D);
        end
    endtask

    task automatic test_misalign;
        access(1'b0, 1'b1, 32'h300, 32'h11223344, 2'd2, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access(1'b0, 1'b1, 32'h302, 32'h99999999, 2'd2, 1'b0, 1'b0);
        access(1'b0, 1'b1, 32'h305, 32'h77777777, 2'd2, 1'b0, 1'b0);
        checks++;
        if (fault_valid_o !== 1'b1 || fault_addr_o !== 32'h302) begin
            errors++;
            $display("FAIL trap_first: got %b/%h expected 1/%h", fault_valid_o, fault_addr_o,
                     32'h302);
        end
        access(1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h11223344) begin
            errors++; $display("FAIL trap_no_write: got %h expected %h", data_o, 32'h11223344);
        end
        access(1'b1, 1'b0, 32'h400, 32'h0, 2'd3, 1'b0, 1'b1);
        checks++;
        if (fault_valid_o !== 1'b1 || fault_addr_o !== 32'h400) begin
            errors++;
            $display("FAIL clr_vs_fault: got %b/%h expected 1/%h", fault_valid_o, fault_addr_o,
                     32'h400);
        end
        checks++;
        if (data_o !== 32'h11223344) begin
            errors++; $display("FAIL trap_no_load: got %h expected %h", data_o, 32'h11223344);
        end
        access(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        checks++;
        if (fault_valid_o !== 1'b0 || fault_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL clr: got %b/%h expected 0/0", fault_valid_o, fault_addr_o);
        end
`else
        access(1'b1, 1'b0, 32'h302, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h11223344) begin
            errors++; $display("FAIL align_word: got %h expected %h", data_o, 32'h11223344);
        end
        access(1'b1, 1'b0, 32'h303, 32'h0, 2'd1, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h00001122) begin
            errors++; $display("FAIL align_half: got %h expected %h", data_o, 32'h00001122);
        end
        access(1'b0, 1'b1, 32'h301, 32'h0000BEEF, 2'd1, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h301, 32'h0, 2'd3, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'h1122BEEF) begin
            errors++; $display("FAIL size3_as_word: got %h expected %h", data_o, 32'h1122BEEF);
        end
        checks++;
        if (fault_valid_o !== 1'b0 || fault_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL fault_tied: got %b/%h expected 0/0", fault_valid_o, fault_addr_o);
        end
`endif
    endtask

    task automatic test_reset_mid;
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (data_o !== 32'h0 || fault_valid_o !== 1'b0 || fault_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h/%b/%h expected 0/0/0", data_o, fault_valid_o,
                     fault_addr_o);
        end
        exp_data = '0; exp_fv = 1'b0; exp_fa = '0;
        #1 rst_ni = 1'b1;
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (data_o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mem_kept: got %h expected %h", data_o, 32'hDEADBEEF);
        end
    endtask

    task automatic test_random;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int k = 0; k < 400; k++) begin
            rd = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 3) == 0);
            a  = $urandom_range(0, 2 * BYTES - 1);
            sz = 2'($urandom_range(0, 3));
            access(rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0));
            checks++;
            if (data_o !== exp_data) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h expected %h", k, data_o, exp_data);
            end
            checks++;
            if (fault_valid_o !== exp_fv || fault_addr_o !== exp_fa) begin
                errors++;
                $display("FAIL rand_fault[%0d]: got %b/%h expected %b/%h", k, fault_valid_o,
                         fault_addr_o, exp_fv, exp_fa);
            end
        end
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_word_store_byte_load();
        test_half_store();
        test_back_to_back();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Single-port byte-addressable data memory that sits directly downstream of the core's memory-access stage. It consumes the core's DMEM request signals (`rd_en`, `wr_en`, `addr`, `data`, `size`, `sign`) presented from the EX-MA register. It returns load data one cycle later, byte-aligned and sign- or zero-extended, so that writeback selects it directly. It performs lane-masked stores, wraps out-of-range addresses, and optionally traps misaligned accesses into a sticky fault register.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `IDX_W`, default `$clog2(DEPTH_WORDS)`: word-index width.
- `clk` input 1: single clock, rising edge.
- `rst_ni` input 1: reset, asynchronous assert, active-low.
- `rd_en_i` input 1: load request, sampled each rising edge.
- `wr_en_i` input 1: store request, sampled each rising edge.
- `addr_i` input 32: byte address.
- `data_i` input 32: store data; the low-order bytes are used for sub-word stores.
- `size_i` input 2: access size. 00 is byte, 01 is halfword, 10 is word, 11 is illegal.
- `sign_i` input 1: 1 sign-extends load data; 0 zero-extends it.
- `data_o` output 32: aligned and extended load data.
- `fault_valid_o` output 1: sticky misalignment or illegal-size fault.
- `fault_addr_o` output 32: address of the first faulting access.
- `fault_clr_i` input 1: clears the fault registers.

## Operation
- **Word index.** The index is `addr_i[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- **Store** (`wr_en_i` high, access legal):
  - Byte: writes `data_i[7:0]` into lane `addr_i[1:0]`.
  - Half: writes `data_i[15:0]` into lanes `{addr_i[1],0}` and `{addr_i[1],1}`.
  - Word: writes all four lanes.
  - Lanes not written are unchanged.
- **Load** (`rd_en_i` high, access legal):
  - The word at the index is read synchronously.
  - `addr_i[1:0]`, `size_i` and `sign_i` are captured into a response register at the same edge.
  - `data_o` is derived combinationally from the registered raw word and the captured fields:
    - Byte: selects the lane, then extends bit 7.
    - Half: selects the half, then extends bit 15.
    - Word: passes the word through unchanged.
- **Both requests high:** the store executes and the load is ignored. The response register and `data_o` hold their previous values.
- **Neither request high:** `data_o` holds the last load result.
- **Legality:**
  - A halfword access with `addr_i[0]=1` is misaligned.
  - A word access with `addr_i[1:0]!=0` is misaligned.
  - `size_i=11` is always illegal.
- **Fault capture:**
  - The first illegal access while `fault_valid_o=0` sets `fault_valid_o` and loads `fault_addr_o` with `addr_i`.
  - Later faults do not overwrite the captured address.
  - `fault_clr_i` clears both registers.
  - If a clear and a new fault occur at the same edge, the new fault wins: valid=1 and the new address is loaded.
- **Reset (`rst_ni` low):** asynchronously clears `data_o` (raw word register and response fields), `fault_valid_o` and `fault_addr_o`. Memory contents are not reset.
  - If reset asserts mid-access, the in-flight load response is discarded; `data_o` reads 0 after release.
  - An access whose edge coincides with reset assertion has no effect.

## Timing
- **Store latency:** the write takes effect at the sampling edge. A load issued in the next cycle sees the new data.
- **Load latency:** exactly 1 cycle. With a request at edge N, `data_o` is valid from just after edge N until the edge that captures the next legal load.
- **No back-pressure:** a request is accepted every cycle, and there is no ready/valid handshake.
- **Fault registers** update at the sampling edge of the faulting access. They are visible the following cycle.
- **Reset values:** `data_o=0`, `fault_valid_o=0`, `fault_addr_o=0`.

## Configuration
- **`DMEM_MISALIGN_TRAP_EN` defined:**
  - An illegal access is suppressed: no memory write, and the load response is unchanged.
  - The access is recorded in the fault registers as described above.
- **`DMEM_MISALIGN_TRAP_EN` undefined:**
  - No fault logic is built; `fault_valid_o` and `fault_addr_o` are tied to 0.
  - Misaligned halfword or word accesses are force-aligned down (`addr_i[0]`, or `addr_i[1:0]`, treated as 0).
  - `size_i=11` is treated as word.

## Test plan
- **Word store, byte loads:** store word 0xDEADBEEF at 0x100, then load byte signed at 0x103. Required: `data_o`=0xFFFFFFDE one cycle later. Unsigned byte at 0x100 must return 0x000000EF.
- **Halfword store, halfword loads:** store half 0x8001 at 0x202. Load half unsigned at 0x202 → 0x00008001. Load half signed → 0xFFFF8001. Load word at 0x200 → 0x8001xxxx, with the low half unchanged from its prior contents.
- **Simultaneous read and write:** drive `rd_en_i=1` and `wr_en_i=1` to 0x10 with data 0x12345678, where the last load result was 0xAAAA5555. Required: `data_o` stays 0xAAAA5555. A following word load at 0x10 returns 0x12345678.
- **Wrap-around** (`DEPTH_WORDS`=1024): store word 0xCAFEF00D at 0x1004, then load word at 0x0004. Required: 0xCAFEF00D.
- **Misaligned trap** (macro defined):
  - Word store to 0x302, then word store to 0x305. Required: memory at 0x300 unchanged, `fault_valid_o=1`, `fault_addr_o`=0x302 (first fault kept).
  - Assert `fault_clr_i` at the same edge as an illegal `size_i=11` access at 0x400. Required: `fault_addr_o`=0x400.
- **Reset mid-access:** issue a load, then pull `rst_ni` low asynchronously between edges. Required: `data_o`, `fault_valid_o` and `fault_addr_o` drop to 0 immediately. After release, a load of previously stored data returns the pre-reset memory contents.
